// File: rtl/exception_trap_controller_if.sv
// Exception/trap bus between the per-stage exception decoders, the fetch and
// hazard units, and the exception trap controller.
//   i_exc_valid/i_exc_code/i_exc_pc/i_exc_tval : packed per-channel requests
//   i_mtvec, i_mret                            : trap vector base, return strobe
//   o_flush, o_redirect_valid, o_redirect_pc   : pipeline control
//   o_trap_active                              : trap permission to the decoders
//   o_mcause/o_mepc/o_mtval                    : latched trap CSRs
//   o_double_fault, o_exc_count                : sticky fault flag, accept count
// master: request/pipeline side.  slave: the controller.
interface exception_trap_controller_if #(
    parameter int XLEN   = 32,
    parameter int N_CH   = 4,
    parameter int CODE_W = 4
);
    logic [N_CH-1:0]        i_exc_valid;
    logic [N_CH*CODE_W-1:0] i_exc_code;
    logic [N_CH*XLEN-1:0]   i_exc_pc;
    logic [N_CH*XLEN-1:0]   i_exc_tval;
    logic [XLEN-1:0]        i_mtvec;
    logic                   i_mret;

    logic                   o_flush;
    logic                   o_redirect_valid;
    logic [XLEN-1:0]        o_redirect_pc;
    logic                   o_trap_active;
    logic [XLEN-1:0]        o_mcause;
    logic [XLEN-1:0]        o_mepc;
    logic [XLEN-1:0]        o_mtval;
    logic                   o_double_fault;
    logic [15:0]            o_exc_count;

    modport master (
        output i_exc_valid, i_exc_code, i_exc_pc, i_exc_tval, i_mtvec, i_mret,
        input  o_flush, o_redirect_valid, o_redirect_pc, o_trap_active,
               o_mcause, o_mepc, o_mtval, o_double_fault, o_exc_count
    );

    modport slave (
        input  i_exc_valid, i_exc_code, i_exc_pc, i_exc_tval, i_mtvec, i_mret,
        output o_flush, o_redirect_valid, o_redirect_pc, o_trap_active,
               o_mcause, o_mepc, o_mtval, o_double_fault, o_exc_count
    );
endinterface

// File: rtl/exception_trap_controller.sv
// Exception trap controller: fixed-priority arbitration of N_CH exception
// channels (highest index = oldest stage wins), trap CSR capture, and the
// flush -> redirect -> trap -> return sequence with double-fault halt.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : exception_trap_controller_if slave (requests in, control/CSRs out)
// All outputs decode from registered state; no path from i_exc_* to outputs.
module exception_trap_controller #(
    parameter int XLEN         = 32,
    parameter int N_CH         = 4,
    parameter int CODE_W       = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    exception_trap_controller_if.slave    bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_FLUSH, ST_REDIRECT, ST_INTRAP, ST_RETURN, ST_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            double_fault_q, double_fault_d;
    logic [15:0]     exc_count_q, exc_count_d;

    logic              any_req;
    logic [CODE_W-1:0] win_code;
    logic [XLEN-1:0]   win_pc;
    logic [XLEN-1:0]   win_tval;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ascending scan: a later (higher-index) requester overwrites earlier ones,
    // giving the oldest stage priority. Code 0 means no exception.
    always_comb begin
        any_req  = 1'b0;
        win_code = '0;
        win_pc   = '0;
        win_tval = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.i_exc_valid[k] && (bus.i_exc_code[k*CODE_W +: CODE_W] != '0)) begin
                any_req  = 1'b1;
                win_code = bus.i_exc_code[k*CODE_W +: CODE_W];
                win_pc   = bus.i_exc_pc[k*XLEN +: XLEN];
                win_tval = bus.i_exc_tval[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        mcause_d       = mcause_q;
        mepc_d         = mepc_q;
        mtval_d        = mtval_q;
        double_fault_d = double_fault_q;
        exc_count_d    = exc_count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    mcause_d    = XLEN'(win_code);
                    mepc_d      = win_pc;
                    mtval_d     = win_tval;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                    exc_count_d = sat_inc16(exc_count_q);
                    state_d     = ST_FLUSH;
                end
            end
            // Requests here come from instructions being flushed; ignore them.
            ST_FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d = ST_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: state_d = ST_INTRAP;
            // A request inside the handler is a double fault and beats mret.
            ST_INTRAP: begin
                if (any_req) begin
                    double_fault_d = 1'b1;
                    state_d        = ST_HALT;
                end else if (bus.i_mret) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            mcause_q       <= '0;
            mepc_q         <= '0;
            mtval_q        <= '0;
            double_fault_q <= 1'b0;
            exc_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            mcause_q       <= mcause_d;
            mepc_q         <= mepc_d;
            mtval_q        <= mtval_d;
            double_fault_q <= double_fault_d;
            exc_count_q    <= exc_count_d;
        end
    end

    assign bus.o_flush          = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT) ||
                                  (state_q == ST_RETURN) || (state_q == ST_HALT);
    assign bus.o_redirect_valid = (state_q == ST_REDIRECT) || (state_q == ST_RETURN);
    assign bus.o_redirect_pc    = (state_q == ST_REDIRECT) ? bus.i_mtvec :
                                  (state_q == ST_RETURN)   ? mepc_q      : '0;
    assign bus.o_trap_active    = (state_q == ST_INTRAP);
    assign bus.o_mcause         = mcause_q;
    assign bus.o_mepc           = mepc_q;
    assign bus.o_mtval          = mtval_q;
    assign bus.o_double_fault   = double_fault_q;
    assign bus.o_exc_count      = exc_count_q;
endmodule
